exec_sequencer: RTL and testbench

//  Instruction-phase sequencer for the BRISC core, driven entirely from CLK with no derived clocks.

---
 rtl/exec_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_exec_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exec_sequencer
// Description : Two-phase instruction sequencer (register-write strobe, then
//               PC-advance strobe) with free run, single step and breakpoint.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_sequencer #(
  parameter int PERIOD   = 50_000_000,
  parameter int PC_W     = 5,
  parameter int DEBOUNCE = 1_000_000,
  parameter int CNT_W    = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            LOAD_DONE,
  input  logic            RUN_SW,
  input  logic            STEP_BTN,
  input  logic [2:0]      RATE_SEL,
  input  logic            BRK_EN,
  input  logic [PC_W-1:0] BRK_ADDR,
  input  logic [PC_W-1:0] PC,
  output logic            REG_WE_STB,
  output logic            PC_ADV_STB,
  output logic            HALTED,
  output logic [1:0]      STATE,
  output logic [15:0]     INSTR_CNT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_EXEC_A = 2'b01,
    S_EXEC_B = 2'b10,
    S_HALT   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0]  c_PERIOD  = CNT_W'(PERIOD);
  localparam int                c_DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE - 1);

  // ---------------------------------------------------------------- step button
  logic              r_sync1;
  logic              r_sync2;
  logic              r_db_level;
  logic              r_press;
  logic [c_DB_W-1:0] r_db_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_level <= 1'b0;
      r_press    <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_sync1 <= STEP_BTN;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_DB_LAST) begin
        // DEBOUNCE consecutive differing samples: accept the new level
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
        r_press    <= r_sync2;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- phase length
  logic [CNT_W-1:0] w_n_sel;

  always_comb begin
    w_n_sel = c_PERIOD >> RATE_SEL;
    if (w_n_sel == '0) w_n_sel = CNT_W'(1);
  end

  // ---------------------------------------------------------------- sequencer
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] w_n_nxt;
  logic             r_skip;
  logic             w_skip_nxt;
  logic             r_step;
  logic             w_step_nxt;
  logic             w_enter;
  logic             w_done;
  logic             w_brk_hit;
  logic             w_we_nxt;
  logic             w_adv_nxt;
  logic             r_we;
  logic             r_adv;
  logic             r_halted;
  logic [15:0]      r_instr;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    w_n_nxt     = r_n;
    w_skip_nxt  = r_skip;
    w_step_nxt  = r_step;
    w_enter     = 1'b0;
    w_done      = (r_cnt >= r_n);
    // r_cnt==1 marks the entry cycle of EXEC_A, when PC shows the new address
    w_brk_hit   = BRK_EN && (PC == BRK_ADDR) && !r_skip && (r_cnt == CNT_W'(1));

    case (r_state)
      S_IDLE: begin
        if (LOAD_DONE) begin
          w_state_nxt = RUN_SW ? S_EXEC_A : S_HALT;
          w_enter     = RUN_SW;
        end
      end
      S_EXEC_A: begin
        if (w_brk_hit) begin
          w_state_nxt = S_HALT;
        end else if (w_done) begin
          w_state_nxt = S_EXEC_B;
          w_enter     = 1'b1;
        end
      end
      S_EXEC_B: begin
        if (w_done) begin
          w_skip_nxt = 1'b0;
          w_step_nxt = 1'b0;
          if (RUN_SW && !r_step) begin
            w_state_nxt = S_EXEC_A;
            w_enter     = 1'b1;
          end else begin
            w_state_nxt = S_HALT;
          end
        end
      end
      default: begin
        if (r_press) begin
          w_skip_nxt  = 1'b1;
          w_step_nxt  = !RUN_SW;
          w_state_nxt = S_EXEC_A;
          w_enter     = 1'b1;
        end
      end
    endcase

    if (w_enter) begin
      w_cnt_nxt = CNT_W'(1);
      w_n_nxt   = w_n_sel;
    end

    if (!LOAD_DONE) begin
      w_state_nxt = S_IDLE;
      w_skip_nxt  = 1'b0;
      w_step_nxt  = 1'b0;
    end

    if (w_state_nxt == S_IDLE || w_state_nxt == S_HALT) w_cnt_nxt = '0;

    w_we_nxt  = (w_state_nxt == S_EXEC_A) && (w_cnt_nxt == w_n_nxt);
    w_adv_nxt = (w_state_nxt == S_EXEC_B) && (w_cnt_nxt == w_n_nxt);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_n      <= '0;
      r_skip   <= 1'b0;
      r_step   <= 1'b0;
      r_we     <= 1'b0;
      r_adv    <= 1'b0;
      r_halted <= 1'b0;
      r_instr  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_n      <= w_n_nxt;
      r_skip   <= w_skip_nxt;
      r_step   <= w_step_nxt;
      r_we     <= w_we_nxt;
      r_adv    <= w_adv_nxt;
      r_halted <= (w_state_nxt == S_HALT);
      if (w_adv_nxt) r_instr <= r_instr + 16'd1;
    end
  end

  assign REG_WE_STB = r_we;
  assign PC_ADV_STB = r_adv;
  assign HALTED     = r_halted;
  assign STATE      = r_state;
  assign INSTR_CNT  = r_instr;

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_sequencer
// Description : Scoreboard bench for exec_sequencer (PERIOD=8, DEBOUNCE=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        LOAD_DONE;
  logic        RUN_SW;
  logic        STEP_BTN;
  logic [2:0]  RATE_SEL;
  logic        BRK_EN;
  logic [4:0]  BRK_ADDR;
  logic [4:0]  PC;
  logic        REG_WE_STB;
  logic        PC_ADV_STB;
  logic        HALTED;
  logic [1:0]  STATE;
  logic [15:0] INSTR_CNT;

  exec_sequencer #(
    .PERIOD  (8),
    .PC_W    (5),
    .DEBOUNCE(16),
    .CNT_W   (32)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .LOAD_DONE (LOAD_DONE),
    .RUN_SW    (RUN_SW),
    .STEP_BTN  (STEP_BTN),
    .RATE_SEL  (RATE_SEL),
    .BRK_EN    (BRK_EN),
    .BRK_ADDR  (BRK_ADDR),
    .PC        (PC),
    .REG_WE_STB(REG_WE_STB),
    .PC_ADV_STB(PC_ADV_STB),
    .HALTED    (HALTED),
    .STATE     (STATE),
    .INSTR_CNT (INSTR_CNT)
  );

  typedef struct {
    bit adv;
    int cyc;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   cyc       = 0;
  int   adv_total = 0;
  int   pc_offset = 0;

  // PC_control model: PC advances once per PC_ADV_STB
  assign PC = 5'(adv_total - pc_offset);

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (REG_WE_STB || PC_ADV_STB) begin
      check("strobe_overlap", int'(REG_WE_STB & PC_ADV_STB), 0);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: got we=%0b adv=%0b at cycle %0d, expected none",
                 REG_WE_STB, PC_ADV_STB, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", int'(PC_ADV_STB), int'(e.adv));
        check("strobe_cycle", cyc, e.cyc);
        check("instr_cnt_at_strobe", int'(INSTR_CNT), e.cnt);
      end
      if (PC_ADV_STB) adv_total++;
    end
  end

  task automatic tick();
    @(negedge CLK);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input bit adv, input int c, input int cnt);
    exp_t e;
    e.adv = adv;
    e.cyc = c;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input int limit);
    int k = 0;
    while (sb.size() != 0 && k < limit) begin
      tick();
      k++;
    end
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  int t0;
  int p;

  initial begin
    RST_N     = 1'b0;
    LOAD_DONE = 1'b0;
    RUN_SW    = 1'b1;
    STEP_BTN  = 1'b0;
    RATE_SEL  = 3'd0;
    BRK_EN    = 1'b0;
    BRK_ADDR  = 5'd0;
    ticks(3);
    RST_N = 1'b1;
    check("rst_state", int'(STATE), 0);
    check("rst_we", int'(REG_WE_STB), 0);
    check("rst_adv", int'(PC_ADV_STB), 0);
    check("rst_halted", int'(HALTED), 0);
    check("rst_instr_cnt", int'(INSTR_CNT), 0);
    ticks(2);

    // Free run, N=8: WE at t0+8, ADV at t0+16, repeating every 16
    t0 = cyc;
    LOAD_DONE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, t0 + 8 + 16 * i, i);
      push(1'b1, t0 + 16 + 16 * i, i + 1);
    end
    wait_empty(100);
    check("run_instr_cnt", int'(INSTR_CNT), 3);
    LOAD_DONE = 1'b0;
    tick();
    check("idle_after_unload", int'(STATE), 0);
    ticks(2);

    // RATE_SEL=7 clamps to N=1: strobes alternate every cycle
    RATE_SEL = 3'd7;
    t0 = cyc;
    LOAD_DONE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, t0 + 1 + 2 * i, 3 + i);
      push(1'b1, t0 + 2 + 2 * i, 4 + i);
    end
    wait_empty(50);
    LOAD_DONE = 1'b0;
    tick();
    check("fast_instr_cnt", int'(INSTR_CNT), 6);
    ticks(2);
    RATE_SEL = 3'd0;

    // Breakpoint at PC=3, then resume with a clean press in run mode
    BRK_EN    = 1'b1;
    BRK_ADDR  = 5'd3;
    pc_offset = adv_total;
    t0 = cyc;
    LOAD_DONE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, t0 + 8 + 16 * i, 6 + i);
      push(1'b1, t0 + 16 + 16 * i, 7 + i);
    end
    wait_empty(100);
    ticks(10);
    check("brk_halted", int'(HALTED), 1);
    check("brk_state", int'(STATE), 3);
    check("brk_instr_cnt", int'(INSTR_CNT), 9);
    p = cyc;
    push(1'b0, p + 26, 9);
    push(1'b1, p + 34, 10);
    push(1'b0, p + 42, 10);
    push(1'b1, p + 50, 11);
    STEP_BTN = 1'b1;
    ticks(40);
    STEP_BTN = 1'b0;
    wait_empty(100);
    check("resume_not_halted", int'(HALTED), 0);
    check("resume_state", int'(STATE), 2);
    LOAD_DONE = 1'b0;
    BRK_EN    = 1'b0;
    ticks(30);

    // Single-step mode: glitches ignored, one long press = one instruction
    RUN_SW    = 1'b0;
    LOAD_DONE = 1'b1;
    ticks(2);
    check("step_idle_to_halt", int'(STATE), 3);
    check("step_halted", int'(HALTED), 1);
    repeat (3) begin
      STEP_BTN = 1'b1;
      ticks(5);
      STEP_BTN = 1'b0;
      ticks(10);
    end
    check("glitch_instr_cnt", int'(INSTR_CNT), 11);
    p = cyc;
    push(1'b0, p + 26, 11);
    push(1'b1, p + 34, 12);
    STEP_BTN = 1'b1;
    ticks(40);
    STEP_BTN = 1'b0;
    ticks(30);
    wait_empty(0);
    check("step_rehalt_state", int'(STATE), 3);
    check("step_rehalt_halted", int'(HALTED), 1);
    check("step_instr_cnt", int'(INSTR_CNT), 12);

    // LOAD_DONE dropped in cycle 3 of EXEC_B
    LOAD_DONE = 1'b0;
    tick();
    RUN_SW = 1'b1;
    t0 = cyc;
    LOAD_DONE = 1'b1;
    push(1'b0, t0 + 8, 12);
    ticks(11);
    check("execb_state_before_drop", int'(STATE), 2);
    LOAD_DONE = 1'b0;
    tick();
    check("drop_state_idle", int'(STATE), 0);
    ticks(10);
    wait_empty(0);
    check("drop_instr_cnt_held", int'(INSTR_CNT), 12);

    // Asynchronous reset in the middle of EXEC_A
    LOAD_DONE = 1'b1;
    ticks(3);
    check("pre_reset_state", int'(STATE), 1);
    RST_N = 1'b0;
    #1;
    check("async_rst_state", int'(STATE), 0);
    check("async_rst_we", int'(REG_WE_STB), 0);
    check("async_rst_adv", int'(PC_ADV_STB), 0);
    check("async_rst_halted", int'(HALTED), 0);
    check("async_rst_instr_cnt", int'(INSTR_CNT), 0);
    ticks(2);
    RST_N = 1'b1;
    t0 = cyc;
    push(1'b0, t0 + 8, 0);
    push(1'b1, t0 + 16, 1);
    wait_empty(100);
    check("post_reset_instr_cnt", int'(INSTR_CNT), 1);
    LOAD_DONE = 1'b0;
    ticks(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
